// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes and FSM states.
// The op codes mirror the MDU_OP_* values decoded by the MIPS EX stage.
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        MDU_OP_MULT  = 3'd0,
        MDU_OP_MULTU = 3'd1,
        MDU_OP_DIV   = 3'd2,
        MDU_OP_DIVU  = 3'd3,
        MDU_OP_MTHI  = 3'd4,
        MDU_OP_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_RUN  = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    function automatic logic is_arith_op(input logic [2:0] op);
        return (op == MDU_OP_MULT) || (op == MDU_OP_MULTU) ||
               (op == MDU_OP_DIV)  || (op == MDU_OP_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
    endfunction

endpackage

// File: rtl/mult_div_unit_shift_core.sv
// Unsigned iterative datapath: one shift-add (multiply) or restoring
// shift-subtract (divide) step per enabled cycle on operand magnitudes.
module mult_div_unit_shift_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] mag_a,
    input  logic [WIDTH-1:0] mag_b,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] sreg,
    output logic             count_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] sreg_reg, sreg_next;
    logic [WIDTH-1:0] op_b_reg;
    logic [CW-1:0]    count_reg, count_next;
    logic             is_div_reg;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   sub_diff;

    always_comb begin
        add_sum  = {1'b0, acc_reg} + (sreg_reg[0] ? {1'b0, op_b_reg} : '0);
        shifted  = {acc_reg, sreg_reg[WIDTH-1]};
        sub_diff = shifted - {1'b0, op_b_reg};
        acc_next   = acc_reg;
        sreg_next  = sreg_reg;
        count_next = count_reg;
        if (load) begin
            acc_next   = '0;
            sreg_next  = mag_a;
            count_next = CW'(WIDTH);
        end else if (step) begin
            count_next = count_reg - CW'(1);
            if (is_div_reg) begin
                // Top bit of the difference is the borrow: set means restore.
                if (!sub_diff[WIDTH]) begin
                    acc_next  = sub_diff[WIDTH-1:0];
                    sreg_next = {sreg_reg[WIDTH-2:0], 1'b1};
                end else begin
                    acc_next  = shifted[WIDTH-1:0];
                    sreg_next = {sreg_reg[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_next  = add_sum[WIDTH:1];
                sreg_next = {add_sum[0], sreg_reg[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_reg    <= '0;
            sreg_reg   <= '0;
            op_b_reg   <= '0;
            count_reg  <= '0;
            is_div_reg <= 1'b0;
        end else begin
            acc_reg   <= acc_next;
            sreg_reg  <= sreg_next;
            count_reg <= count_next;
            if (load) begin
                op_b_reg   <= mag_b;
                is_div_reg <= is_div;
            end
        end
    end

    assign acc        = acc_reg;
    assign sreg       = sreg_reg;
    assign count_zero = (count_reg == '0);

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers for the EX stage.
// Owns the FSM, sign handling, HI/LO and the pipeline stall handshake.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             rd_hilo,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             stall_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_e state_reg, state_next;
    logic [WIDTH-1:0] hi_reg, hi_next;
    logic [WIDTH-1:0] lo_reg, lo_next;
    logic neg_main_reg, neg_main_next;
    logic neg_rem_reg, neg_rem_next;
    logic is_div_reg, is_div_next;
    logic dbz_reg, dbz_next;

    logic op_is_arith, op_is_div, a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] core_acc, core_sreg;
    logic core_load, core_step, count_zero;
    logic [2*WIDTH-1:0] product, product_fix;
    logic [WIDTH-1:0] quot_fix, rem_fix;

    always_comb begin
        op_is_arith = is_arith_op(op);
        op_is_div   = is_div_op(op);
        a_neg       = is_signed_op(op) & src_a[WIDTH-1];
        b_neg       = is_signed_op(op) & src_b[WIDTH-1];
        mag_a       = a_neg ? -src_a : src_a;
        mag_b       = b_neg ? -src_b : src_b;
        // MIN / -1 falls out naturally: the magnitude quotient 2^(W-1) negates to itself.
        product     = {core_acc, core_sreg};
        product_fix = neg_main_reg ? -product : product;
        quot_fix    = neg_main_reg ? -core_sreg : core_sreg;
        rem_fix     = neg_rem_reg ? -core_acc : core_acc;
    end

    mult_div_unit_shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (core_load),
        .step       (core_step),
        .is_div     (op_is_div),
        .mag_a      (mag_a),
        .mag_b      (mag_b),
        .acc        (core_acc),
        .sreg       (core_sreg),
        .count_zero (count_zero)
    );

    always_comb begin
        state_next    = state_reg;
        hi_next       = hi_reg;
        lo_next       = lo_reg;
        neg_main_next = neg_main_reg;
        neg_rem_next  = neg_rem_reg;
        is_div_next   = is_div_reg;
        dbz_next      = dbz_reg;
        core_load     = 1'b0;
        core_step     = 1'b0;
        case (state_reg)
            MDU_IDLE: begin
                if (start && !kill) begin
                    if (op_is_arith) begin
                        core_load     = 1'b1;
                        state_next    = MDU_RUN;
                        is_div_next   = op_is_div;
                        neg_main_next = a_neg ^ b_neg;
                        neg_rem_next  = a_neg;
                        dbz_next      = op_is_div && (src_b == '0);
                    end else if (op == MDU_OP_MTHI) begin
                        hi_next = src_a;
                    end else if (op == MDU_OP_MTLO) begin
                        lo_next = src_a;
                    end
                end
            end
            MDU_RUN: begin
                // Divide-by-zero skips the iterations but keeps the final
                // write cycle, so it reaches DONE one edge after issue.
                if (kill) begin
                    state_next = MDU_IDLE;
                end else if (count_zero || dbz_reg) begin
                    state_next = MDU_DONE;
                    if (!dbz_reg) begin
                        if (is_div_reg) begin
                            hi_next = rem_fix;
                            lo_next = quot_fix;
                        end else begin
                            hi_next = product_fix[2*WIDTH-1:WIDTH];
                            lo_next = product_fix[WIDTH-1:0];
                        end
                    end
                end else begin
                    core_step = 1'b1;
                end
            end
            MDU_DONE: state_next = MDU_IDLE;
            default:  state_next = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= MDU_IDLE;
            hi_reg       <= '0;
            lo_reg       <= '0;
            neg_main_reg <= 1'b0;
            neg_rem_reg  <= 1'b0;
            is_div_reg   <= 1'b0;
            dbz_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            hi_reg       <= hi_next;
            lo_reg       <= lo_next;
            neg_main_reg <= neg_main_next;
            neg_rem_reg  <= neg_rem_next;
            is_div_reg   <= is_div_next;
            dbz_reg      <= dbz_next;
        end
    end

    assign busy        = (state_reg != MDU_IDLE);
    assign done        = (state_reg == MDU_DONE) && !kill;
    assign div_by_zero = done && dbz_reg;
    assign stall_req   = busy && (start || rd_hilo);
    assign hi          = hi_reg;
    assign lo          = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: arithmetic/timing reference model checked every cycle,
// plus directed vectors with hand-computed HI/LO and latency.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n, start, rd_hilo, kill;
    logic [2:0]   op;
    logic [W-1:0] src_a, src_b;
    logic         busy, done, div_by_zero, stall_req;
    logic [W-1:0] hi, lo;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .rd_hilo(rd_hilo), .kill(kill),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .stall_req(stall_req), .hi(hi), .lo(lo)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: {hi, lo} from plain 64-bit integer operators.
    function automatic logic [63:0] calc(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [63:0] sa, sb, sq, sr;
        logic [63:0] ua, ub, uq, ur;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        calc = 64'd0;
        case (o)
            MDU_OP_MULT:  begin sq = sa * sb; calc = sq; end
            MDU_OP_MULTU: begin uq = ua * ub; calc = uq; end
            MDU_OP_DIV:   if (b != 0) begin sq = sa / sb; sr = sa % sb; calc = {sr[31:0], sq[31:0]}; end
            MDU_OP_DIVU:  if (b != 0) begin uq = ua / ub; ur = ua % ub; calc = {ur[31:0], uq[31:0]}; end
            default:      calc = 64'd0;
        endcase
    endfunction

    // Behavioural model: cycles-to-done countdown plus architectural HI/LO.
    logic [W-1:0] m_hi, m_lo;
    logic [63:0]  m_res;
    bit           m_busy, m_done, m_dbz;
    int           m_left;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_hi <= '0; m_lo <= '0; m_busy <= 0; m_done <= 0; m_dbz <= 0; m_left <= 0;
        end else if (m_busy) begin
            if (kill || m_done) begin
                m_busy <= 0;
                m_done <= 0;
            end else if (m_left == 1) begin
                m_done <= 1;
                m_left <= 0;
                if (!m_dbz) begin
                    m_hi <= m_res[63:32];
                    m_lo <= m_res[31:0];
                end
            end else begin
                m_left <= m_left - 1;
            end
        end else if (start && !kill) begin
            if (op <= 3'd3) begin
                m_busy <= 1;
                m_res  <= calc(op, src_a, src_b);
                m_dbz  <= ((op == MDU_OP_DIV) || (op == MDU_OP_DIVU)) && (src_b == 0);
                m_left <= (((op == MDU_OP_DIV) || (op == MDU_OP_DIVU)) && (src_b == 0)) ? 1 : W + 1;
            end else if (op == MDU_OP_MTHI) begin
                m_hi <= src_a;
            end else if (op == MDU_OP_MTLO) begin
                m_lo <= src_a;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", busy, m_busy);
            check("cyc_done", done, m_done & ~kill);
            check("cyc_dbz", div_by_zero, m_done & ~kill & m_dbz);
            check("cyc_stall", stall_req, m_busy & (start | rd_hilo));
            check("cyc_hi", hi, m_hi);
            check("cyc_lo", lo, m_lo);
        end
    end

    // Drive start for one cycle; returns 1ns after the accepting edge (edge 0).
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk); #1;
        start = 1; op = o; src_a = a; src_b = b;
        @(posedge clk); #1;
        start = 0;
    endtask

    // Returns at the negedge of the done cycle; cyc = edges after edge 0.
    task automatic wait_done(output int cyc, output bit got);
        cyc = 0;
        got = 0;
        while (cyc < 100 && !got) begin
            @(negedge clk);
            if (done) got = 1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int exp_lat,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input bit exp_dbz);
        int cyc;
        bit got;
        issue(o, a, b);
        wait_done(cyc, got);
        check({name, "_latency"}, cyc, exp_lat);
        check({name, "_hi"}, hi, exp_hi);
        check({name, "_lo"}, lo, exp_lo);
        check({name, "_dbz"}, div_by_zero, exp_dbz);
        $display("[TB] %s a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h dbz=%0d latency=%0d",
                 name, a, b, hi, lo, div_by_zero, cyc);
    endtask

    task automatic move_to(input string name, input logic [2:0] o, input logic [W-1:0] d);
        issue(o, d, '0);
        @(negedge clk);
        check({name, "_val"}, (o == MDU_OP_MTHI) ? hi : lo, d);
        check({name, "_busy"}, busy, 0);
        $display("[TB] %s 0x%08h -> hi=0x%08h lo=0x%08h", name, d, hi, lo);
    endtask

    task automatic watch_no_done(input string name, input int n);
        bit seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check({name, "_no_done"}, seen, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bit got;
        rst_n = 0; start = 0; op = '0; src_a = '0; src_b = '0; rd_hilo = 0; kill = 0;
        chk_en = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);

        run_op("mult_neg3x7", MDU_OP_MULT, 32'hFFFF_FFFD, 32'd7, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        run_op("multu_max", MDU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 32'h0000_0001, 0);
        run_op("div_neg7by2", MDU_OP_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_op("divu_7by2", MDU_OP_DIVU, 32'd7, 32'd2, 33, 32'd1, 32'd3, 0);
        run_op("div_min_by_m1", MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000, 0);
        run_op("div_100_by_m7", MDU_OP_DIV, 32'd100, 32'hFFFF_FFF9, 33, 32'd2, 32'hFFFF_FFF2, 0);
        run_op("mult_m5xm6", MDU_OP_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 33, 32'd0, 32'd30, 0);

        move_to("mthi", MDU_OP_MTHI, 32'h11);
        move_to("mtlo", MDU_OP_MTLO, 32'h22);
        run_op("div_by_zero", MDU_OP_DIV, 32'd5, 32'd0, 1, 32'h11, 32'h22, 1);

        // Kill ten cycles into a multiply: no write, no done.
        issue(MDU_OP_MULT, 32'd1234, 32'd5678);
        repeat (9) @(posedge clk);
        #1 kill = 1;
        @(posedge clk); #1 kill = 0;
        @(negedge clk);
        check("kill_busy", busy, 0);
        watch_no_done("kill", 40);
        check("kill_hi", hi, 32'h11);
        check("kill_lo", lo, 32'h22);
        $display("[TB] kill mid-MULT -> busy=%0d hi=0x%08h lo=0x%08h", busy, hi, lo);

        // Stall requests while busy; the start during busy must be dropped.
        issue(MDU_OP_DIVU, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        #1 rd_hilo = 1;
        @(negedge clk);
        check("stall_rd_hilo", stall_req, 1);
        @(posedge clk); #1 rd_hilo = 0; start = 1; op = MDU_OP_MTHI; src_a = 32'hDEAD;
        @(negedge clk);
        check("stall_start", stall_req, 1);
        @(posedge clk); #1 start = 0;
        wait_done(cyc, got);
        check("stall_got_done", got, 1);
        check("stall_hi", hi, 32'd2);
        check("stall_lo", lo, 32'd14);
        $display("[TB] DIVU 100/7 with stalls -> hi=0x%08h lo=0x%08h", hi, lo);

        // Reset in the middle of RUN clears HI/LO.
        issue(MDU_OP_MULT, 32'h1234, 32'h5678);
        repeat (5) @(posedge clk);
        #1 rst_n = 0;
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        check("rstrun_hi", hi, 0);
        check("rstrun_lo", lo, 0);
        check("rstrun_busy", busy, 0);
        $display("[TB] reset mid-RUN -> busy=%0d hi=0x%08h lo=0x%08h", busy, hi, lo);

        // kill in IDLE beats start.
        @(posedge clk); #1 start = 1; kill = 1; op = MDU_OP_MTHI; src_a = 32'hBEEF;
        @(posedge clk); #1 start = 0; kill = 0;
        @(negedge clk);
        check("idlekill_hi", hi, 0);
        check("idlekill_busy", busy, 0);
        $display("[TB] kill+start in IDLE -> busy=%0d hi=0x%08h", busy, hi);

        // kill coinciding with the final RUN cycle still wins.
        move_to("mtlo2", MDU_OP_MTLO, 32'h55);
        issue(MDU_OP_MULT, 32'd3, 32'd3);
        repeat (32) @(posedge clk);
        #1 kill = 1;
        @(posedge clk); #1 kill = 0;
        @(negedge clk);
        check("lastkill_busy", busy, 0);
        watch_no_done("lastkill", 5);
        check("lastkill_hi", hi, 0);
        check("lastkill_lo", lo, 32'h55);
        $display("[TB] kill on final RUN cycle -> busy=%0d hi=0x%08h lo=0x%08h", busy, hi, lo);

        run_op("recover_divu", MDU_OP_DIVU, 32'hFFFF_FFFF, 32'h10, 33, 32'hF, 32'h0FFF_FFFF, 0);

        @(negedge clk);
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
